// File: rtl/shell_uart_pkg.sv
// shell_uart_pkg: shared FSM type, parity codes and baud divisor helper for the shell UART
package shell_uart_pkg;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction
endpackage

// File: rtl/shell_uart_fifo.sv
// shell_uart_fifo: single-clock first-word-fall-through FIFO with occupancy count
module shell_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_rd,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign w_wr    = i_wr && !o_full;
    assign w_rd    = i_rd && !o_empty;
    assign o_dout  = r_mem[r_rptr];
    assign o_count = r_count;
    // storage is not reset: flushing only needs the pointers and count cleared
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wptr] <= i_din;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= w_wr ? r_wptr + 1'b1 : r_wptr;
            r_rptr  <= w_rd ? r_rptr + 1'b1 : r_rptr;
            r_count <= (w_wr && !w_rd) ? r_count + (AW+1)'(1) :
                       (w_rd && !w_wr) ? r_count - (AW+1)'(1) : r_count;
        end
    end
endmodule

// File: rtl/shell_uart_tx.sv
// shell_uart_tx: AXI-Stream fed UART transmitter with byte FIFO, optional parity and 1/2 stop bits
module shell_uart_tx #(
    parameter int CLK_FREQ_HZ = 250000000,
    parameter int BAUD        = 115200,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [7:0]                    s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic                          uart_txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    import shell_uart_pkg::*;
    localparam int DIV = uart_div(CLK_FREQ_HZ, BAUD);
    localparam int BW  = $clog2(DIV);
    if (DIV < 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_chk
        $error("shell_uart_tx: baud divisor must be >= 2 and STOP_BITS must be 1 or 2");
    end
    state_t                        r_state;
    state_t                        w_next;
    logic [BW-1:0]                 r_baud;
    logic [2:0]                    r_bit;
    logic [7:0]                    r_shift;
    logic                          r_txd;
    logic                          r_busy;
    logic                          w_tick;
    logic                          w_last_stop;
    logic                          w_pop;
    logic                          w_txd;
    logic                          w_full;
    logic                          w_empty;
    logic [7:0]                    w_dout;
    logic [$clog2(FIFO_DEPTH):0]   w_count;
    shell_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .i_wr    (s_axis_tvalid),
        .i_din   (s_axis_tdata),
        .i_rd    (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );
    assign w_tick        = r_baud == BW'(DIV - 1);
    assign w_last_stop   = r_state == S_STOP && w_tick && r_bit == 3'(STOP_BITS - 1);
    assign w_pop         = !w_empty && (r_state == S_IDLE || w_last_stop);
    assign s_axis_tready = !w_full && aresetn;
    assign uart_txd      = r_txd;
    assign busy          = r_busy;
    assign fifo_count    = w_count;
    always_ff @(posedge aclk) begin
        r_state <= !aresetn ? S_IDLE : w_next;
    end
    // popping on the last stop cycle chains frames with no idle gap
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = w_pop ? S_START : S_IDLE;
            S_START:  w_next = w_tick ? S_DATA : S_START;
            S_DATA:   w_next = (w_tick && r_bit == 3'd7) ? (PARITY != PAR_NONE ? S_PARITY : S_STOP) : S_DATA;
            S_PARITY: w_next = w_tick ? S_STOP : S_PARITY;
            S_STOP:   w_next = w_last_stop ? (w_pop ? S_START : S_IDLE) : S_STOP;
            default:  w_next = S_IDLE;
        endcase
    end
    always_comb begin
        w_txd = 1'b1;
        case (r_state)
            S_START:  w_txd = 1'b0;
            S_DATA:   w_txd = r_shift[r_bit];
            S_PARITY: w_txd = PARITY == PAR_EVEN ? ^r_shift : ~^r_shift;
            default:  w_txd = 1'b1;
        endcase
    end
    // line bit is registered from the current state, so it trails the state by one cycle
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_baud  <= (r_state == S_IDLE || w_tick) ? '0 : r_baud + 1'b1;
            r_bit   <= (r_state != w_next) ? '0 : w_tick ? r_bit + 1'b1 : r_bit;
            r_shift <= w_pop ? w_dout : r_shift;
            r_txd   <= w_txd;
            r_busy  <= r_state != S_IDLE || w_count != '0;
        end
    end
endmodule
